// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MEM,
    WB,
    FAULT
  } seq_state_t;

  localparam logic [1:0]  NPC_SEQ   = 2'b00;
  localparam logic [1:0]  NPC_REL   = 2'b01;
  localparam logic [1:0]  NPC_ABS   = 2'b11;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Next PC from the decoder select; 2'b10 is treated as sequential.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [1:0] sel,
                                          input logic [31:0] addr);
    logic [31:0] npc;
    case (sel)
      NPC_REL: npc = pc + addr;
      NPC_ABS: npc = addr;
      default: npc = pc + 32'd4;
    endcase
    return npc;
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Bus wait-cycle counter. o_expired flags the cycle in which a counted wait
// would make the count reach i_limit; a limit of 0 never expires.
module seq_timeout_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_cnt_en,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_inc;

  assign w_count_inc = r_count + WIDTH'(1);
  assign o_expired   = i_cnt_en && (i_limit != '0) && (w_count_inc == i_limit);

  // Count waiting cycles; cleared on reset and on every sequencer state change.
  always_ff @(posedge clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_cnt_en) begin
      r_count <= w_count_inc;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the RV32I core: owns PC and instruction register
// and shares the single memory port between fetch and load/store.
// Optional performance counters are built when SEQ_PERF_COUNTERS_EN is defined.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_i,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  output logic        mem_we_o,
  output logic        mem_fetch_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        decoder_en_o,
  input  logic [1:0]  next_pc_sel_i,
  input  logic [31:0] addr_i,
  input  logic        addr_valid_i,
  input  logic        d_we_i,
  input  logic        reg_in_en_i,
  output logic        reg_we_o,
  output logic        load_capture_o,
  output logic        retire_o,
  output logic        fault_o
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [63:0] cycle_count_o,
  output logic [63:0] instret_count_o
`endif
);

  seq_state_t  r_state;
  seq_state_t  w_state_d;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        w_expired;
  logic        w_wait;

  assign pc_o    = r_pc;
  assign instr_o = r_instr;
  assign w_wait  = mem_req_o && !mem_ack_i;

  seq_timeout_counter #(
    .WIDTH(32)
  ) u_timeout (
    .clk      (clk),
    .i_reset  (reset_i),
    .i_clear  (w_state_d != r_state),
    .i_cnt_en (w_wait),
    .i_limit  (32'(TIMEOUT_CYCLES)),
    .o_expired(w_expired)
  );

  // Next-state and strobe decode; strobes are forced low while reset is asserted.
  always_comb begin
    w_state_d      = r_state;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_fetch_o    = 1'b0;
    mem_addr_o     = r_pc;
    decoder_en_o   = 1'b0;
    reg_we_o       = 1'b0;
    load_capture_o = 1'b0;
    retire_o       = 1'b0;
    fault_o        = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req_o   = 1'b1;
        mem_fetch_o = 1'b1;
        // Ack wins over a timeout in the same cycle.
        if (mem_ack_i) begin
          w_state_d = DECODE;
        end else if (w_expired) begin
          w_state_d = FAULT;
        end
      end
      DECODE: begin
        decoder_en_o = 1'b1;
        w_state_d    = addr_valid_i ? MEM : WB;
      end
      MEM: begin
        decoder_en_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_we_o     = d_we_i;
        mem_addr_o   = addr_i;
        if (mem_ack_i) begin
          load_capture_o = !d_we_i;
          w_state_d      = WB;
        end else if (w_expired) begin
          w_state_d = FAULT;
        end
      end
      WB: begin
        decoder_en_o = 1'b1;
        reg_we_o     = reg_in_en_i;
        retire_o     = 1'b1;
        w_state_d    = FETCH;
      end
      FAULT: begin
        fault_o = 1'b1;
      end
      default: begin
        w_state_d = FAULT;
      end
    endcase
    if (reset_i) begin
      mem_req_o      = 1'b0;
      decoder_en_o   = 1'b0;
      reg_we_o       = 1'b0;
      load_capture_o = 1'b0;
      retire_o       = 1'b0;
    end
  end

  // State, PC and instruction register.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else begin
      r_state <= w_state_d;
      if (r_state == FETCH && mem_ack_i) begin
        r_instr <= mem_rdata_i;
      end
      if (r_state == WB) begin
        r_pc <= next_pc(r_pc, next_pc_sel_i, addr_i);
      end
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  logic [63:0] r_cycle_count;
  logic [63:0] r_instret_count;

  // Free-running cycle and retired-instruction counters, wrapping at 2^64.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_cycle_count   <= '0;
      r_instret_count <= '0;
    end else begin
      r_cycle_count <= r_cycle_count + 64'd1;
      if (retire_o) begin
        r_instret_count <= r_instret_count + 64'd1;
      end
    end
  end

  assign cycle_count_o   = r_cycle_count;
  assign instret_count_o = r_instret_count;
`endif

endmodule
